// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the load/store control sequencer.
//   state_e      : FSM states IDLE, T0..T7, DONE
//   OPC_*        : opcode encodings taken from IR[31:27]
//   ALU_ADD      : ALUControl code for add
//   MEM_TIMEOUT  : default bound on MemReady wait cycles per access
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE
  } state_e;

  localparam logic [4:0] OPC_LD  = 5'b00000;
  localparam logic [4:0] OPC_LDI = 5'b00001;
  localparam logic [4:0] OPC_ST  = 5'b00010;
  localparam logic [4:0] ALU_ADD = 5'b00011;

  localparam int MEM_TIMEOUT = 15;

endpackage

// File: rtl/ldst_control_sequencer_mem_wait_timer.sv
// mem_wait_timer: clearable wait-cycle counter for one memory access.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : hold the counter at zero (asserted outside wait states)
//   i_inc          : count one wait cycle (in a wait state with MemReady low)
//   o_tc           : this wait cycle is the MEM_TIMEOUT-th one; the access
//                    times out on the coming edge
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  // Flag fires while the count still reads MEM_TIMEOUT-1, so the FSM can
  // leave the wait state on the same edge that the count would reach the limit.
  assign o_tc = i_inc && (r_cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/ldst_control_sequencer.sv
// ldst_control_sequencer: Moore FSM sequencing ld / ldi / st through T0..T7.
//   Clock, GlobalReset     : clock, asynchronous active-low reset
//   Start                  : begin an instruction (accepted in IDLE or DONE)
//   IR                     : instruction register from the datapath
//   MemReady               : memory completes the current access this cycle
//   PCout..write           : datapath strobes
//   ALUControl             : ALU op select (ALU_ADD in T4 only)
//   Busy, Done, Error      : status; Error is sticky until reset / accepted Start
module ldst_control_sequencer #(
  parameter int              OPC_W       = 5,
  parameter logic [OPC_W-1:0] OPC_LD     = OPC_W'(cpu_ctrl_pkg::OPC_LD),
  parameter logic [OPC_W-1:0] OPC_LDI    = OPC_W'(cpu_ctrl_pkg::OPC_LDI),
  parameter logic [OPC_W-1:0] OPC_ST     = OPC_W'(cpu_ctrl_pkg::OPC_ST),
  parameter logic [4:0]      ALU_ADD     = cpu_ctrl_pkg::ALU_ADD,
  parameter int              MEM_TIMEOUT = cpu_ctrl_pkg::MEM_TIMEOUT
) (
  input  logic        Clock,
  input  logic        GlobalReset,
  input  logic        Start,
  input  logic [31:0] IR,
  input  logic        MemReady,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zloout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Grb,
  output logic        BAout,
  output logic        Yin,
  output logic        Cout,
  output logic        Gra,
  output logic        Rin,
  output logic        Rout,
  output logic        write,
  output logic [4:0]  ALUControl,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  import cpu_ctrl_pkg::*;

  state_e           r_state, w_next;
  logic             r_error;
  logic [OPC_W-1:0] w_opc;
  logic             w_is_ld, w_is_ldi, w_is_st, w_legal;
  logic             w_wait, w_tmo, w_start_acc;
  logic             w_unused_ir;

  assign w_opc       = IR[31 -: OPC_W];
  assign w_unused_ir = ^IR[31-OPC_W:0];
  assign w_is_ld     = (w_opc == OPC_LD);
  assign w_is_ldi    = (w_opc == OPC_LDI);
  assign w_is_st     = (w_opc == OPC_ST);
  assign w_legal     = w_is_ld | w_is_ldi | w_is_st;

  // Wait states: fetch read, ld operand read, st write.
  assign w_wait = (r_state == T1) ||
                  (r_state == T6 && w_is_ld) ||
                  (r_state == T7 && w_is_st);

  // Non-wait states separate every pair of wait states, so holding the
  // counter clear outside them gives a fresh count on each entry.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .i_clk   (Clock),
    .i_rst_n (GlobalReset),
    .i_clr   (!w_wait),
    .i_inc   (w_wait && !MemReady),
    .o_tc    (w_tmo)
  );

  assign w_start_acc = Start && (r_state == IDLE || r_state == DONE);

  // State register
  always_ff @(posedge Clock or negedge GlobalReset) begin
    if (!GlobalReset) r_state <= IDLE;
    else              r_state <= w_next;
  end

  // Next-state logic; MemReady wins over a timeout in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (Start) w_next = T0;
      T0:   w_next = T1;
      T1:   w_next = MemReady ? T2 : (w_tmo ? IDLE : T1);
      T2:   w_next = T3;
      T3:   w_next = w_legal ? T4 : IDLE;
      T4:   w_next = T5;
      T5:   w_next = w_is_ldi ? DONE : T6;
      T6:   if (w_is_ld) w_next = MemReady ? T7 : (w_tmo ? IDLE : T6);
            else         w_next = T7;
      T7:   if (w_is_st) w_next = MemReady ? DONE : (w_tmo ? IDLE : T7);
            else         w_next = DONE;
      DONE: w_next = Start ? T0 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge GlobalReset) begin
    if (!GlobalReset)                         r_error <= 1'b0;
    else if (w_start_acc)                     r_error <= 1'b0;
    else if ((r_state == T3 && !w_legal) || w_tmo) r_error <= 1'b1;
  end

  // Output decode from the registered state (IR only selects the ld/ldi/st
  // variant, and is stable from T3 on).
  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin   = 1'b0;
    Zloout = 1'b0; PCin = 1'b0; Read  = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Grb   = 1'b0; BAout = 1'b0;
    Yin   = 1'b0; Cout  = 1'b0; Gra   = 1'b0; Rin   = 1'b0;
    Rout  = 1'b0; write = 1'b0; ALUControl = 5'b0;
    Busy  = (r_state != IDLE);
    Done  = (r_state == DONE);
    case (r_state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zloout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      // An illegal opcode is detected here; suppress strobes in that cycle.
      T3: if (w_legal) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      T4: begin Cout = 1'b1; Zin = 1'b1; ALUControl = ALU_ADD; end
      T5: begin
        Zloout = 1'b1;
        if (w_is_ldi) begin Gra = 1'b1; Rin = 1'b1; end
        else          MARin = 1'b1;
      end
      T6: begin
        MDRin = 1'b1;
        if (w_is_st) begin Gra = 1'b1; Rout = 1'b1; end
        else         Read = 1'b1;
      end
      T7: begin
        if (w_is_st) write = 1'b1;
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      default: ;
    endcase
  end

  assign Error = r_error;

endmodule

// File: tb/tb_ldst_control_sequencer.sv
module tb_ldst_control_sequencer;

  logic        Clock = 1'b0;
  logic        GlobalReset = 1'b0;
  logic        Start = 1'b0;
  logic        MemReady = 1'b1;
  logic [31:0] IR = 32'h0;
  logic PCout, MARin, IncPC, Zin, Zloout, PCin, Read, MDRin, MDRout, IRin;
  logic Grb, BAout, Yin, Cout, Gra, Rin, Rout, write, Busy, Done, Error;
  logic [4:0] ALUControl;

  ldst_control_sequencer dut (
    .Clock(Clock), .GlobalReset(GlobalReset), .Start(Start), .IR(IR),
    .MemReady(MemReady), .PCout(PCout), .MARin(MARin), .IncPC(IncPC),
    .Zin(Zin), .Zloout(Zloout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Grb(Grb), .BAout(BAout), .Yin(Yin),
    .Cout(Cout), .Gra(Gra), .Rin(Rin), .Rout(Rout), .write(write),
    .ALUControl(ALUControl), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  // Observed vector layout: 18 strobes, ALUControl[4:0], Busy, Done, Error.
  localparam logic [25:0] B_PCOUT  = 26'h1 << 25;
  localparam logic [25:0] B_MARIN  = 26'h1 << 24;
  localparam logic [25:0] B_INCPC  = 26'h1 << 23;
  localparam logic [25:0] B_ZIN    = 26'h1 << 22;
  localparam logic [25:0] B_ZLOOUT = 26'h1 << 21;
  localparam logic [25:0] B_PCIN   = 26'h1 << 20;
  localparam logic [25:0] B_READ   = 26'h1 << 19;
  localparam logic [25:0] B_MDRIN  = 26'h1 << 18;
  localparam logic [25:0] B_MDROUT = 26'h1 << 17;
  localparam logic [25:0] B_IRIN   = 26'h1 << 16;
  localparam logic [25:0] B_GRB    = 26'h1 << 15;
  localparam logic [25:0] B_BAOUT  = 26'h1 << 14;
  localparam logic [25:0] B_YIN    = 26'h1 << 13;
  localparam logic [25:0] B_COUT   = 26'h1 << 12;
  localparam logic [25:0] B_GRA    = 26'h1 << 11;
  localparam logic [25:0] B_RIN    = 26'h1 << 10;
  localparam logic [25:0] B_ROUT   = 26'h1 << 9;
  localparam logic [25:0] B_WRITE  = 26'h1 << 8;
  localparam logic [25:0] B_ADD    = {18'b0, 5'b00011, 3'b000};
  localparam logic [25:0] B_BUSY   = 26'h1 << 2;
  localparam logic [25:0] B_DONE   = 26'h1 << 1;
  localparam logic [25:0] B_ERR    = 26'h1;

  localparam logic [25:0] E_IDLE   = 26'h0;
  localparam logic [25:0] E_T0     = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_BUSY;
  localparam logic [25:0] E_T1     = B_ZLOOUT | B_PCIN | B_READ | B_MDRIN | B_BUSY;
  localparam logic [25:0] E_T2     = B_MDROUT | B_IRIN | B_BUSY;
  localparam logic [25:0] E_T3     = B_GRB | B_BAOUT | B_YIN | B_BUSY;
  localparam logic [25:0] E_T3BAD  = B_BUSY;
  localparam logic [25:0] E_T4     = B_COUT | B_ZIN | B_ADD | B_BUSY;
  localparam logic [25:0] E_T5LDI  = B_ZLOOUT | B_GRA | B_RIN | B_BUSY;
  localparam logic [25:0] E_T5MEM  = B_ZLOOUT | B_MARIN | B_BUSY;
  localparam logic [25:0] E_T6LD   = B_READ | B_MDRIN | B_BUSY;
  localparam logic [25:0] E_T6ST   = B_GRA | B_ROUT | B_MDRIN | B_BUSY;
  localparam logic [25:0] E_T7LD   = B_MDROUT | B_GRA | B_RIN | B_BUSY;
  localparam logic [25:0] E_T7ST   = B_WRITE | B_BUSY;
  localparam logic [25:0] E_DONE   = B_DONE | B_BUSY;

  typedef struct {
    string       tag;
    logic [25:0] exp;
    logic        start;
    logic        mr;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [25:0] obs();
    return {PCout, MARin, IncPC, Zin, Zloout, PCin, Read, MDRin, MDRout, IRin,
            Grb, BAout, Yin, Cout, Gra, Rin, Rout, write, ALUControl,
            Busy, Done, Error};
  endfunction

  task automatic check(input string tag, input logic [25:0] exp);
    logic [25:0] o;
    o = obs();
    n_chk++;
    assert (o === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, o, exp);
  endtask

  // One entry per clock cycle: Start/MemReady to drive during the cycle and
  // the output vector expected in it.
  task automatic push(input string tag, input logic [25:0] exp,
                      input logic st = 1'b0, input logic mr = 1'b1);
    exp_t e;
    e.tag = tag; e.exp = exp; e.start = st; e.mr = mr;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge Clock);
      #1;
      Start    = e.start;
      MemReady = e.mr;
      #1;
      check(e.tag, e.exp);
    end
  endtask

  task automatic push_front_end(input logic [25:0] t3);
    push("T0", E_T0); push("T1", E_T1); push("T2", E_T2); push("T3", t3);
  endtask

  initial begin
    // Reset state
    #2 check("reset", E_IDLE);
    #8 GlobalReset = 1'b1;
    #1 check("idle_after_reset", E_IDLE);

    // ld, MemReady high: T0..T7 in cycles 1-8, DONE in cycle 9
    IR = 32'h0080_0000; Start = 1'b1;
    push_front_end(E_T3); push("ld_T4", E_T4); push("ld_T5", E_T5MEM);
    push("ld_T6", E_T6LD); push("ld_T7", E_T7LD); push("ld_DONE", E_DONE);
    push("ld_IDLE", E_IDLE);
    drain();

    // ldi twice back-to-back: DONE in cycle 7, Start in DONE skips IDLE
    IR = 32'h0880_0000; Start = 1'b1;
    push_front_end(E_T3); push("ldi_T4", E_T4); push("ldi_T5", E_T5LDI);
    push("ldi_DONE", E_DONE, 1'b1);
    push_front_end(E_T3); push("ldi2_T4", E_T4); push("ldi2_T5", E_T5LDI);
    push("ldi2_DONE", E_DONE); push("ldi2_IDLE", E_IDLE);
    drain();

    // st with 3 MemReady-low cycles in T7: write held 4 cycles
    IR = 32'h1000_0000; Start = 1'b1;
    push_front_end(E_T3); push("st_T4", E_T4); push("st_T5", E_T5MEM);
    push("st_T6", E_T6ST);
    for (int i = 0; i < 3; i++) push("st_T7_wait", E_T7ST, 1'b0, 1'b0);
    push("st_T7_rdy", E_T7ST); push("st_DONE", E_DONE); push("st_IDLE", E_IDLE);
    drain();

    // Illegal opcode: no strobes in T3, Error next cycle, Start clears it
    IR = 32'hF800_0000; Start = 1'b1;
    push_front_end(E_T3BAD);
    push("bad_err", B_ERR, 1'b1);
    push_front_end(E_T3BAD);
    push("bad_err2", B_ERR); push("bad_err_hold", B_ERR);
    drain();

    // Timeout: MemReady stuck low in T1 for MEM_TIMEOUT (15) wait cycles
    IR = 32'h0080_0000; Start = 1'b1;
    push("to_T0", E_T0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) push("to_T1_wait", E_T1, 1'b0, 1'b0);
    push("to_err", B_ERR); push("to_err_hold", B_ERR);
    drain();

    // MemReady on the 15th wait cycle wins over the timeout
    Start = 1'b1;
    push("pl_T0", E_T0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) push("pl_T1_wait", E_T1, 1'b0, 1'b0);
    push("pl_T1_rdy", E_T1);
    push("pl_T2", E_T2); push("pl_T3", E_T3); push("pl_T4", E_T4);
    push("pl_T5", E_T5MEM); push("pl_T6", E_T6LD); push("pl_T7", E_T7LD);
    push("pl_DONE", E_DONE); push("pl_IDLE", E_IDLE);
    drain();

    // Asynchronous reset in the middle of the ld T6 read
    Start = 1'b1;
    push_front_end(E_T3); push("rs_T4", E_T4); push("rs_T5", E_T5MEM);
    push("rs_T6_wait", E_T6LD, 1'b0, 1'b0); push("rs_T6_wait2", E_T6LD, 1'b0, 1'b0);
    drain();
    #3 GlobalReset = 1'b0;
    #1 check("rst_async", E_IDLE);
    #10 GlobalReset = 1'b1; MemReady = 1'b1;
    push("rs_idle", E_IDLE); push("rs_idle2", E_IDLE);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ldst_control_sequencer.md
# ldst_control_sequencer

Parametrised control-step sequencer for the load/store instruction family (ld, ldi, st). It replaces hand-sequenced T0..T8 stimulus with a hardware FSM that drives the existing datapath control strobes. Memory accesses use a ready handshake with a bounded wait. It sits beside `new_datapath`, takes `IR` back from it, and owns every strobe that a load/store touches.

## Interface
- `OPC_W`, 5: opcode width, taken from `IR[31:32-OPC_W]`
- `OPC_LD`, 5'b00000: ld opcode
- `OPC_LDI`, 5'b00001: ldi opcode
- `OPC_ST`, 5'b00010: st opcode
- `ALU_ADD`, 5'b00011: ALUControl code for add
- `MEM_TIMEOUT`, 15: maximum wait cycles for MemReady in one access; must be ≥1
- `Clock  in  1`: single clock; all state changes on the rising edge
- `GlobalReset  in  1`: asynchronous, active-low reset
- `Start  in  1`: begin a fetch/execute when the block is in IDLE
- `IR  in  32`: instruction register contents from the datapath
- `MemReady  in  1`: memory completes the current Read or write access this cycle
- `PCout, MARin, IncPC, Zin, Zloout, PCin, Read, MDRin, MDRout, IRin, Grb, BAout, Yin, Cout, Gra, Rin, Rout, write  out  1`: datapath strobes
- `ALUControl  out  5`: ALU operation select
- `Busy  out  1`: high in every state except IDLE
- `Done  out  1`: one-cycle pulse when an instruction completes
- `Error  out  1`: sticky flag for an illegal opcode or a memory timeout; cleared by reset or by accepted Start

## Operation
- Moore FSM. Outputs decode combinationally from the registered state. Only the strobes listed for a state are high; every other output is 0.
- States and strobes:
  - IDLE: no strobes.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zloout, PCin, Read, MDRin (memory wait).
  - T2: MDRout, IRin.
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, ALUControl=ALU_ADD.
  - T5: Zloout, plus Gra and Rin for ldi, or MARin for ld/st.
  - T6 for ld: Read, MDRin (memory wait).
  - T6 for st: Gra, Rout, MDRin.
  - T7 for ld: MDRout, Gra, Rin.
  - T7 for st: write (memory wait).
  - DONE: Done=1.
- ALUControl = 0 in every state except T4.
- Transitions:
  - IDLE→T0 on Start.
  - T0→T1→T2→T3→T4→T5 unconditionally, except wait states.
  - T5→DONE for ldi; T5→T6 for ld/st.
  - T6→T7.
  - T7→DONE.
  - DONE→T0 if Start is high, else IDLE.
- Opcode decode: `IR[31:27]` is sampled combinationally in T3. IR is stable from T3 onward because IRin is only high in T2.
- Illegal opcode in T3: set Error and go to IDLE. No strobes are issued in that cycle.
- Memory wait states (T1, ld-T6, st-T7):
  - The state holds, and its strobes stay asserted, until a cycle with MemReady=1. The FSM advances on that edge.
  - A wait counter clears on entry to each wait state and increments per cycle with MemReady=0.
  - When the counter reaches MEM_TIMEOUT: set Error, go to IDLE, deassert all strobes.
- Start is ignored while Busy, except in DONE.
- Reset (asynchronous, any state, including mid-access):
  - State goes to IDLE, wait counter to 0, Error to 0.
  - All outputs go to 0 immediately, without waiting for a clock edge.

## Timing
- Reset value of every output: 0.
- ld / st with MemReady tied high: Start sampled at edge 0. Then T0..T7 occupy cycles 1–8, DONE is cycle 9, and Busy is high in cycles 1–9.
- ldi: DONE is cycle 7.
- Each MemReady=0 cycle adds one cycle to the current access.
- Back-to-back: Start held high in DONE gives T0 in the next cycle, with no IDLE bubble.
- Timeout: with MemReady held at 0, Error rises and Busy falls on the edge after the MEM_TIMEOUT-th consecutive wait cycle.
- A MemReady=1 in that same cycle takes precedence and the access completes.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - State enum: IDLE, T0..T7, DONE.
  - Opcode constants: OPC_LD, OPC_LDI, OPC_ST.
  - ALU code ALU_ADD.
- Natural sub-module: `mem_wait_timer`, a clearable counter with a terminal-count flag at MEM_TIMEOUT.
- State register and output decode stay in the top module.

## Test plan
- Reset mid-T6 with Read high → Read, MDRin and Busy go to 0 with no clock edge. After release, the block is in IDLE and Error=0.
- ld with IR=32'h00800000 and MemReady=1 → strobes T0..T7 exactly as listed. ALUControl=5'b00011 only in T4. Done pulses in cycle 9.
- ldi with IR=32'h08800000 → Gra, Rin and Zloout high in T5. Done in cycle 7. No second Read after T1.
- st with MemReady low for 3 cycles in T7 → write held high for 4 cycles. Done follows 1 cycle later. Error=0.
- Opcode 5'b11111 → Error=1 in the cycle after T3, then IDLE. A following Start clears Error and enters T0.
- MEM_TIMEOUT=15, MemReady stuck at 0 in T1 → Error=1 and Busy=0 after 15 wait cycles. A MemReady=1 pulse on wait cycle 15 → normal advance, Error=0.
